ray_tri_sequencer: RTL and testbench

Sequential driver for the combinational ray/triangle intersection unit. It accepts one ray over a valid/ready handshake and streams triangles from a synchronous triangle memory into the intersection unit at one triangle per cycle. It keeps the closest valid hit, then returns index, t and normal over a valid/ready result handshake. It sits between the ray generator and the shading stage and owns the triangle memory read port.

---
 rtl/rt_pkg.sv | 20 ++
 rtl/hit_accumulator.sv | 80 ++++++++
 rtl/ray_tri_sequencer.sv | 129 ++++++++++++
 tb/tb_ray_tri_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared ray-tracing types: Q16.16 vectors, rays, triangles and sequencer states.
// Ports: none (package only).
// Vectors are [x,y,z]; a ray is [origin, direction]; a triangle is [v0, v1, v2].
package rt_pkg;

   typedef logic [0:2][31:0] vec3_t;
   typedef vec3_t [0:1]      ray_t;
   typedef vec3_t [0:2]      triangle_t;

   localparam logic signed [31:0] FIX_ONE       = 32'sh00010000;
   localparam logic signed [31:0] T_MAX_DEFAULT = 32'sh7FFFFFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_e;

endpackage

// File: rtl/hit_accumulator.sv
// Closest-hit accumulator: keeps best t, index and normal, plus hit and sticky invalid flags.
// Ports: i_init clears to the empty state; i_upd_vld presents one intersection result per cycle.
// Outputs are registered and change only on the edge after i_init or i_upd_vld.
module hit_accumulator
   import rt_pkg::*;
#(
   parameter int                 IDX_W  = 10,
   parameter logic signed [31:0] T_INIT = T_MAX_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    i_init,
   input  logic                    i_upd_vld,
   input  logic                    i_result,
   input  logic                    i_invalid,
   input  logic signed [31:0]      i_t,
   input  logic [IDX_W-1:0]        i_idx,
   input  vec3_t                   i_normal,
   output logic                    o_hit,
   output logic [IDX_W-1:0]        o_best_idx,
   output logic signed [31:0]      o_best_t,
   output vec3_t                   o_best_normal,
   output logic                    o_any_invalid
);

   logic               hit_q,    hit_d;
   logic [IDX_W-1:0]   idx_q,    idx_d;
   logic signed [31:0] best_t_q, best_t_d;
   vec3_t              nrm_q,    nrm_d;
   logic               inv_q,    inv_d;

   always_comb begin
      hit_d    = hit_q;
      idx_d    = idx_q;
      best_t_d = best_t_q;
      nrm_d    = nrm_q;
      inv_d    = inv_q;
      if (i_init) begin
         hit_d    = 1'b0;
         idx_d    = '0;
         best_t_d = T_INIT;
         nrm_d    = '0;
         inv_d    = 1'b0;
      end else if (i_upd_vld) begin
         if (i_invalid) begin
            // An overflowing evaluation is flagged but never competes as a hit.
            inv_d = 1'b1;
         end else if (i_result && (i_t < best_t_q)) begin
            // Strict compare: on equal t the earlier (lower) index is kept.
            hit_d    = 1'b1;
            idx_d    = i_idx;
            best_t_d = i_t;
            nrm_d    = i_normal;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hit_q    <= 1'b0;
         idx_q    <= '0;
         best_t_q <= T_INIT;
         nrm_q    <= '0;
         inv_q    <= 1'b0;
      end else begin
         hit_q    <= hit_d;
         idx_q    <= idx_d;
         best_t_q <= best_t_d;
         nrm_q    <= nrm_d;
         inv_q    <= inv_d;
      end
   end

   assign o_hit         = hit_q;
   assign o_best_idx    = idx_q;
   assign o_best_t      = best_t_q;
   assign o_best_normal = nrm_q;
   assign o_any_invalid = inv_q;

endmodule

// File: rtl/ray_tri_sequencer.sv
// Ray/triangle sequencer: takes one ray, streams N triangles (1/cycle) from a sync memory
// through a combinational intersection unit, and returns the closest hit.
// Ports: ray valid/ready in, triangle memory read port, intersection unit I/O, hit valid/ready out.
module ray_tri_sequencer
   import rt_pkg::*;
#(
   parameter int                 TRI_AW = 10,
   parameter logic signed [31:0] T_MAX  = T_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_ray_valid,
   output logic                 o_ray_ready,
   input  ray_t                 i_ray,
   input  logic [TRI_AW:0]      i_num_tris,
   output logic                 o_tri_rd,
   output logic [TRI_AW-1:0]    o_tri_addr,
   input  triangle_t            i_tri_data,
   output ray_t                 o_isect_ray,
   output triangle_t            o_isect_triangle,
   input  logic                 i_isect_result,
   input  logic                 i_isect_invalid,
   input  logic signed [31:0]   i_isect_t,
   input  vec3_t                i_isect_normal,
   output logic                 o_hit_valid,
   input  logic                 i_hit_ready,
   output logic                 o_hit,
   output logic [TRI_AW-1:0]    o_hit_index,
   output logic signed [31:0]   o_hit_t,
   output vec3_t                o_hit_normal,
   output logic                 o_any_invalid
);

   localparam logic [TRI_AW:0] MAX_TRIS = {1'b1, {TRI_AW{1'b0}}};

   seq_state_e          state_q, state_d;
   ray_t                ray_q;
   logic [TRI_AW:0]     cnt_q;
   logic [TRI_AW-1:0]   idx_q;
   logic                drain_q;
   logic                rd_dly_q;     // a read was issued last cycle; data is on i_tri_data now
   logic [TRI_AW-1:0]   rd_idx_q;
   triangle_t           tri_q;
   logic [TRI_AW-1:0]   tri_idx_q;
   logic                tri_vld_q;

   logic                accept;
   logic                last_issue;
   logic [TRI_AW:0]     num_sat;

   assign accept     = i_ray_valid && (state_q == ST_IDLE);
   assign num_sat    = (i_num_tris > MAX_TRIS) ? MAX_TRIS : i_num_tris;
   assign last_issue = ({1'b0, idx_q} == (cnt_q - 1'b1));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = (num_sat == '0) ? ST_DONE : ST_SCAN;
         ST_SCAN:  if (last_issue) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q) state_d = ST_DONE;
         ST_DONE:  if (i_hit_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ray_q     <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         drain_q   <= 1'b0;
         rd_dly_q  <= 1'b0;
         rd_idx_q  <= '0;
         tri_q     <= '0;
         tri_idx_q <= '0;
         tri_vld_q <= 1'b0;
      end else begin
         if (accept) begin
            ray_q <= i_ray;
            cnt_q <= num_sat;
            idx_q <= '0;
         end else if ((state_q == ST_SCAN) && !last_issue) begin
            // Index stops on the last issued address so o_tri_addr holds it afterwards.
            idx_q <= idx_q + 1'b1;
         end
         drain_q   <= (state_q == ST_DRAIN) ? ~drain_q : 1'b0;
         rd_dly_q  <= o_tri_rd;
         rd_idx_q  <= idx_q;
         tri_vld_q <= rd_dly_q;
         if (rd_dly_q) begin
            tri_q     <= i_tri_data;
            tri_idx_q <= rd_idx_q;
         end
      end
   end

   assign o_ray_ready      = (state_q == ST_IDLE);
   assign o_tri_rd         = (state_q == ST_SCAN);
   assign o_tri_addr       = idx_q;
   assign o_isect_ray      = ray_q;
   assign o_isect_triangle = tri_q;
   assign o_hit_valid      = (state_q == ST_DONE);

   hit_accumulator #(
      .IDX_W  (TRI_AW),
      .T_INIT (T_MAX)
   ) u_acc (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_init        (accept),
      .i_upd_vld     (tri_vld_q),
      .i_result      (i_isect_result),
      .i_invalid     (i_isect_invalid),
      .i_t           (i_isect_t),
      .i_idx         (tri_idx_q),
      .i_normal      (i_isect_normal),
      .o_hit         (o_hit),
      .o_best_idx    (o_hit_index),
      .o_best_t      (o_hit_t),
      .o_best_normal (o_hit_normal),
      .o_any_invalid (o_any_invalid)
   );

endmodule

// File: tb/tb_ray_tri_sequencer.sv
module tb_ray_tri_sequencer;
   import rt_pkg::*;

   localparam int AW = 3;
   localparam int NT = 8;
   localparam logic [31:0] TMAX = 32'h7FFFFFFF;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              i_ray_valid;
   logic              o_ray_ready;
   ray_t              i_ray;
   logic [AW:0]       i_num_tris;
   logic              o_tri_rd;
   logic [AW-1:0]     o_tri_addr;
   triangle_t         i_tri_data;
   ray_t              o_isect_ray;
   triangle_t         o_isect_triangle;
   logic              i_isect_result;
   logic              i_isect_invalid;
   logic [31:0]       i_isect_t;
   vec3_t             i_isect_normal;
   logic              o_hit_valid;
   logic              i_hit_ready;
   logic              o_hit;
   logic [AW-1:0]     o_hit_index;
   logic [31:0]       o_hit_t;
   vec3_t             o_hit_normal;
   logic              o_any_invalid;

   always #5 clk = ~clk;

   ray_tri_sequencer #(.TRI_AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_ray_valid(i_ray_valid), .o_ray_ready(o_ray_ready), .i_ray(i_ray), .i_num_tris(i_num_tris),
      .o_tri_rd(o_tri_rd), .o_tri_addr(o_tri_addr), .i_tri_data(i_tri_data),
      .o_isect_ray(o_isect_ray), .o_isect_triangle(o_isect_triangle),
      .i_isect_result(i_isect_result), .i_isect_invalid(i_isect_invalid),
      .i_isect_t(i_isect_t), .i_isect_normal(i_isect_normal),
      .o_hit_valid(o_hit_valid), .i_hit_ready(i_hit_ready), .o_hit(o_hit),
      .o_hit_index(o_hit_index), .o_hit_t(o_hit_t), .o_hit_normal(o_hit_normal),
      .o_any_invalid(o_any_invalid)
   );

   // Triangle memory and intersection responder. Each triangle carries its id in v0.x,
   // and the responder answers from per-id tables.
   triangle_t   mem     [NT];
   logic        res_tab [NT];
   logic        inv_tab [NT];
   logic [31:0] t_tab   [NT];
   vec3_t       nrm_tab [NT];
   logic [AW-1:0] cur_id;

   assign cur_id          = o_isect_triangle[0][0][AW-1:0];
   assign i_isect_result  = res_tab[cur_id];
   assign i_isect_invalid = inv_tab[cur_id];
   assign i_isect_t       = t_tab[cur_id];
   assign i_isect_normal  = nrm_tab[cur_id];

   always @(posedge clk) if (o_tri_rd) i_tri_data <= mem[o_tri_addr];

   int cyc = 0;
   int rd_total = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (o_tri_rd) rd_total <= rd_total + 1;

   typedef struct {
      logic          hit;
      logic [AW-1:0] idx;
      logic [31:0]   t;
      vec3_t         nrm;
      logic          inv;
      int            lat;
      int            nrd;
      ray_t          ray;
   } exp_t;

   exp_t sb[$];
   int n_checks = 0;
   int n_errors = 0;
   int c0 = 0;
   int rd_base = 0;

   task automatic chk(input string tag, input logic [287:0] act, input logic [287:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, expv);
      end
   endtask

   function automatic exp_t model(input ray_t r, input int n);
      exp_t e;
      int neff;
      neff  = (n > NT) ? NT : n;
      e.hit = 1'b0; e.idx = '0; e.t = TMAX; e.nrm = '0; e.inv = 1'b0; e.ray = r;
      e.lat = (neff == 0) ? 1 : neff + 3;
      e.nrd = neff;
      for (int i = 0; i < neff; i++) begin
         if (inv_tab[i]) e.inv = 1'b1;
         else if (res_tab[i] && ($signed(t_tab[i]) < $signed(e.t))) begin
            e.hit = 1'b1; e.idx = i[AW-1:0]; e.t = t_tab[i]; e.nrm = nrm_tab[i];
         end
      end
      return e;
   endfunction

   task automatic clear_tabs();
      for (int i = 0; i < NT; i++) begin
         res_tab[i] = 1'b0; inv_tab[i] = 1'b0; t_tab[i] = '0;
      end
   endtask

   task automatic set_tri(input int i, input logic r, input logic v, input logic [31:0] t);
      res_tab[i] = r; inv_tab[i] = v; t_tab[i] = t;
   endtask

   task automatic send_ray(input ray_t r, input int n, input bit track);
      int w;
      if (track) sb.push_back(model(r, n));
      @(negedge clk);
      i_ray = r; i_num_tris = n[AW:0]; i_ray_valid = 1'b1;
      w = 0;
      while (!o_ray_ready && w < 50) begin @(negedge clk); w++; end
      if (!o_ray_ready) chk("ray_ready_timeout", 288'(o_ray_ready), 288'(1));
      c0 = cyc; rd_base = rd_total;
      @(negedge clk);
      i_ray_valid = 1'b0;
   endtask

   task automatic get_result(input int hold);
      exp_t e;
      int w;
      w = 0;
      while (!o_hit_valid && w < 100) begin @(negedge clk); w++; end
      if (!o_hit_valid) begin
         chk("hit_valid_timeout", 288'(o_hit_valid), 288'(1));
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 288'(sb.size()), 288'(1));
         return;
      end
      e = sb.pop_front();
      chk("latency",    288'(cyc - c0),           288'(e.lat));
      chk("hit",        288'(o_hit),              288'(e.hit));
      chk("hit_index",  288'(o_hit_index),        288'(e.idx));
      chk("hit_t",      288'(o_hit_t),            288'(e.t));
      chk("hit_normal", 288'(o_hit_normal),       288'(e.nrm));
      chk("any_inv",    288'(o_any_invalid),      288'(e.inv));
      chk("isect_ray",  288'(o_isect_ray),        288'(e.ray));
      chk("rd_count",   288'(rd_total - rd_base), 288'(e.nrd));
      chk("ray_rdy_done", 288'(o_ray_ready),      288'(0));
      if (hold > 0) begin
         repeat (hold) @(negedge clk);
         chk("bp_valid",     288'(o_hit_valid),        288'(1));
         chk("bp_ray_ready", 288'(o_ray_ready),        288'(0));
         chk("bp_index",     288'(o_hit_index),        288'(e.idx));
         chk("bp_t",         288'(o_hit_t),            288'(e.t));
         chk("bp_normal",    288'(o_hit_normal),       288'(e.nrm));
         chk("bp_rd_count",  288'(rd_total - rd_base), 288'(e.nrd));
      end
      i_hit_ready = 1'b1;
      @(negedge clk);
      i_hit_ready = 1'b0;
      chk("idle_ray_ready", 288'(o_ray_ready), 288'(1));
      chk("idle_valid",     288'(o_hit_valid), 288'(0));
   endtask

   ray_t ray_a, ray_b;

   initial begin
      reset_n = 1'b0; i_ray_valid = 1'b0; i_hit_ready = 1'b0;
      i_ray = '0; i_num_tris = '0;
      for (int i = 0; i < NT; i++) begin
         mem[i] = '0;
         mem[i][0][0] = 32'(i);
         mem[i][1][1] = FIX_ONE;
         mem[i][2][2] = 32'(i) + 32'h00020000;
         nrm_tab[i] = {FIX_ONE, 32'(i + 1), 32'hA5A50000};
      end
      clear_tabs();
      ray_a = '0; ray_a[0][2] = 32'hFFFB0000; ray_a[1][2] = FIX_ONE;
      ray_b = '0; ray_b[0][0] = 32'h00018000; ray_b[1][0] = 32'hFFFF0000; ray_b[1][1] = 32'h00004000;

      repeat (2) @(negedge clk);
      chk("rst_ray_ready", 288'(o_ray_ready),      288'(1));
      chk("rst_valid",     288'(o_hit_valid),      288'(0));
      chk("rst_tri_rd",    288'(o_tri_rd),         288'(0));
      chk("rst_hit_t",     288'(o_hit_t),          288'(TMAX));
      chk("rst_hit",       288'(o_hit),            288'(0));
      chk("rst_any_inv",   288'(o_any_invalid),    288'(0));
      chk("rst_isect_tri", 288'(o_isect_triangle), 288'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Single hit
      clear_tabs(); set_tri(0, 1, 0, 32'h00050000);
      send_ray(ray_a, 1, 1); get_result(0);

      // Closest of three with a tie
      clear_tabs();
      set_tri(0, 1, 0, 32'h00070000); set_tri(1, 1, 0, 32'h00030000); set_tri(2, 1, 0, 32'h00030000);
      send_ray(ray_b, 3, 1); get_result(0);

      // Invalid and miss
      clear_tabs(); set_tri(0, 1, 1, 32'h00010000); set_tri(1, 0, 0, 32'h00020000);
      send_ray(ray_a, 2, 1); get_result(0);

      // Empty scene
      clear_tabs(); set_tri(0, 1, 0, 32'h00010000);
      send_ray(ray_b, 0, 1); get_result(0);

      // t equal to T_MAX is not a hit
      clear_tabs(); set_tri(0, 1, 0, TMAX);
      send_ray(ray_a, 1, 1); get_result(0);

      // Backpressure, then the next ray must be accepted
      clear_tabs(); set_tri(0, 1, 0, 32'h00040000); set_tri(1, 1, 0, 32'h00020000);
      send_ray(ray_b, 2, 1); get_result(10);

      // Saturated count, negative t, closest hit on the last triangle
      clear_tabs();
      set_tri(0, 1, 0, 32'h00080000); set_tri(2, 1, 0, 32'hFFFF0000); set_tri(4, 1, 1, 32'hFFF00000);
      set_tri(5, 1, 0, 32'h00010000); set_tri(7, 1, 0, 32'hFFFE0000);
      send_ray(ray_a, 15, 1); get_result(0);

      // Reset in cycle 3 of an 8-triangle scan
      clear_tabs(); set_tri(0, 1, 1, 32'h00010000); set_tri(1, 1, 0, 32'h00010000);
      send_ray(ray_a, 8, 0);
      @(negedge clk); @(negedge clk);
      chk("pre_rst_tri_rd", 288'(o_tri_rd), 288'(1));
      reset_n = 1'b0;
      #1;
      chk("mid_rst_tri_rd",    288'(o_tri_rd),         288'(0));
      chk("mid_rst_ray_ready", 288'(o_ray_ready),      288'(1));
      chk("mid_rst_valid",     288'(o_hit_valid),      288'(0));
      chk("mid_rst_hit_t",     288'(o_hit_t),          288'(TMAX));
      chk("mid_rst_isect_tri", 288'(o_isect_triangle), 288'(0));
      @(negedge clk);
      reset_n = 1'b1;

      // Clean restart: all misses, T_MAX and any_invalid=0 restored
      clear_tabs(); set_tri(1, 0, 0, 32'h00010000);
      send_ray(ray_b, 3, 1); get_result(0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
